// File: rtl/code_digit_emitter_pkg.sv
// Shared definitions for the keypad code-to-digit emitter.
package code_digit_emitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SKIP    = 2'd2,
        ST_EMIT    = 2'd3
    } state_e;

    localparam int BCD_W         = 4;
    localparam int KEY_DIGIT_MAX = 9;

endpackage

// File: rtl/code_digit_emitter_if.sv
// Start/value request plus digit stream handshake between the emitter and its consumer.
interface code_digit_emitter_if import code_digit_emitter_pkg::*; #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic [BCD_W-1:0] digit;
    logic             digit_valid;
    logic             digit_ready;
    logic             last;
    logic             done;

    modport master (
        output start, value, digit_ready,
        input  busy, digit, digit_valid, last, done
    );

    modport slave (
        input  start, value, digit_ready,
        output busy, digit, digit_valid, last, done
    );

endinterface

// File: rtl/code_digit_emitter_bcd_add3.sv
// Double-dabble correction cell: a nibble above half the largest digit gets +3.
module bcd_add3 import code_digit_emitter_pkg::*; (
    input  logic [BCD_W-1:0] d_i,
    output logic [BCD_W-1:0] q_o
);

    // Add 3 to nibbles of 5 or more so the following left shift carries into the next digit
    always_comb begin
        q_o = (d_i > BCD_W'(KEY_DIGIT_MAX / 2)) ? d_i + BCD_W'(3) : d_i;
    end

endmodule

// File: rtl/code_digit_emitter.sv
// Binary code to decimal digit stream: sequential double-dabble, then MS-first emission
// of the digits without leading zeros over a valid/ready handshake.
module code_digit_emitter import code_digit_emitter_pkg::*; #(
    parameter int WIDTH   = 32,
    parameter int NDIGITS = 10
) (
    input  logic                  hwclk,
    input  logic                  reset,
    code_digit_emitter_if.slave   bus
);

    localparam int CNT_W   = $clog2(WIDTH + 1);
    localparam int IDX_W   = $clog2(NDIGITS);
    localparam int BCD_TOT = NDIGITS * BCD_W;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCD_TOT-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic [BCD_W-1:0]   digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   cur_nib, next_nib;
    logic               hs;

    function automatic logic [BCD_W-1:0] nibble(input logic [BCD_TOT-1:0] bcd,
                                                input logic [IDX_W-1:0]   idx);
        return bcd[int'(idx) * BCD_W +: BCD_W];
    endfunction

    for (genvar g = 0; g < NDIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i (bcd_q[g*BCD_W +: BCD_W]),
            .q_o (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    assign hs       = valid_q & bus.digit_ready;
    assign cur_nib  = nibble(bcd_q, idx_q);
    assign next_nib = nibble(bcd_q, idx_q - IDX_W'(1));

    assign bus.busy        = busy_q;
    assign bus.digit       = digit_q;
    assign bus.digit_valid = valid_q;
    assign bus.last        = last_q;
    assign bus.done        = done_q;

    // State, datapath and output registers; reset clears everything asynchronously
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            digit_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Next-state: convert for WIDTH cycles, skip leading zeros, emit until the last handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.start) state_d = ST_CONVERT;
            ST_CONVERT: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_SKIP;
            ST_SKIP:    if (!(cur_nib == '0 && idx_q != '0)) state_d = ST_EMIT;
            ST_EMIT:    if (hs && idx_q == '0) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values, keyed on the current state
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        digit_d = digit_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        busy_d  = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_d = bus.value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) idx_d = IDX_W'(NDIGITS - 1);
            end
            ST_SKIP: begin
                if (cur_nib == '0 && idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else begin
                    digit_d = cur_nib;
                    valid_d = 1'b1;
                    last_d  = (idx_q == '0);
                end
            end
            ST_EMIT: begin
                if (hs) begin
                    if (idx_q != '0) begin
                        idx_d   = idx_q - IDX_W'(1);
                        digit_d = next_nib;
                        last_d  = (idx_q == IDX_W'(1));
                    end else begin
                        digit_d = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_code_digit_emitter.sv
// Bench for code_digit_emitter: vector table of conversions plus hand-written corner cases,
// digits checked against a decimal scoreboard filled when each start is driven.
module tb_code_digit_emitter;
    import code_digit_emitter_pkg::*;

    localparam int WIDTH   = 32;
    localparam int NDIGITS = 10;

    logic hwclk = 1'b0;
    logic reset = 1'b1;

    code_digit_emitter_if #(.WIDTH(WIDTH)) bus ();

    code_digit_emitter #(.WIDTH(WIDTH), .NDIGITS(NDIGITS)) dut (
        .hwclk (hwclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 hwclk = ~hwclk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [4:0] sb[$];   // {last, digit}

    typedef struct {
        logic [31:0] value;
        int          lat;
        int          n;
        bit          bp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Decimal digits of v, most significant first, last flag on the final one
    task automatic push_expected(input logic [31:0] v);
        logic [3:0]  d[$];
        logic [31:0] t;
        t = v;
        do begin
            d.push_front(4'(t % 10));
            t = t / 10;
        end while (t != 0);
        for (int i = 0; i < d.size(); i++)
            sb.push_back({(i == d.size() - 1), d[i]});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        sb.delete();
        @(posedge hwclk);
        #2 reset = 1'b0;
    endtask

    // Monitor: scoreboard pop on each handshake, stall stability, done pulse width
    logic       prev_stall = 1'b0;
    logic [3:0] prev_digit = '0;
    logic       prev_last  = 1'b0;
    logic       prev_done  = 1'b0;
    always @(negedge hwclk) begin
        if (reset) begin
            prev_stall <= 1'b0;
            prev_done  <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", bus.digit_valid, 1);
                check("stall_digit", bus.digit, prev_digit);
                check("stall_last", bus.last, prev_last);
            end
            if (bus.digit_valid && bus.digit_ready) begin
                check("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) check("digit_last", {bus.last, bus.digit}, sb.pop_front());
            end
            if (bus.done) begin
                done_cnt <= done_cnt + 1;
                check("done_width", prev_done, 0);
            end
            prev_done  <= bus.done;
            prev_stall <= bus.digit_valid && !bus.digit_ready;
            prev_digit <= bus.digit;
            prev_last  <= bus.last;
        end
    end

    task automatic run_one(input logic [31:0] v, input int exp_lat, input int exp_n,
                           input bit bp, input bit poke, input string tag);
        int lat, k, stall, d0;
        d0 = done_cnt;
        push_expected(v);
        bus.digit_ready = !bp;
        @(posedge hwclk);
        #2 bus.start = 1'b1; bus.value = v;
        @(posedge hwclk);
        #1 bus.start = 1'b0; bus.value = $urandom;
        lat = 0;
        while (!bus.digit_valid && lat < 200) begin
            @(posedge hwclk);
            #1 lat++;
            bus.start = poke && (lat == 5);
            bus.value = (poke && lat == 5) ? 32'd7 : $urandom;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_run"}, bus.busy, 1);
        k = 0;
        stall = 0;
        while (!bus.done && k < 400) begin
            #1;
            if (bp) begin
                if (stall == 3) begin bus.digit_ready = 1'b1; stall = 0; end
                else begin bus.digit_ready = 1'b0; stall++; end
            end
            @(posedge hwclk);
            #1 k++;
        end
        check({tag, "_done_lat"}, k, bp ? 4 * exp_n : exp_n);
        check({tag, "_busy_done"}, bus.busy, 0);
        bus.digit_ready = 1'b1;
        @(posedge hwclk);
        #1;
        check({tag, "_valid_after"}, bus.digit_valid, 0);
        check({tag, "_done_drop"}, bus.done, 0);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        if (lat >= 200 || k >= 400) do_reset();
    endtask

    initial begin
        int lat, cyc, seen, d0;

        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cyc, seen, d0;

        vecs[0] = '{32'd123456,     37,  6, 1'b0};
        vecs[1] = '{32'd0,          42,  1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF,   33, 10, 1'b0};
        vecs[3] = '{32'd905,        40,  3, 1'b1};
        vecs[4] = '{32'd1000000000, 33, 10, 1'b0};
        vecs[5] = '{32'd9,          42,  1, 1'b1};
        vecs[6] = '{32'd10,         41,  2, 1'b0};

        bus.start       = 1'b0;
        bus.value       = '0;
        bus.digit_ready = 1'b1;
        reset           = 1'b1;
        repeat (3) @(posedge hwclk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_valid", bus.digit_valid, 0);
        check("rst_digit", bus.digit, 0);
        check("rst_last", bus.last, 0);
        check("rst_done", bus.done, 0);
        #1 reset = 1'b0;

        for (int i = 0; i < 7; i++)
            run_one(vecs[i].value, vecs[i].lat, vecs[i].n, vecs[i].bp, 1'b0,
                    $sformatf("vec%0d", i));

        // start pulsed with value 7 mid-conversion must be ignored
        run_one(32'd123456, 37, 6, 1'b0, 1'b1, "poke");

        // reset while the third digit of 123456 is on offer
        d0 = done_cnt;
        push_expected(32'd123456);
        bus.digit_ready = 1'b1;
        @(posedge hwclk);
        #2 bus.start = 1'b1; bus.value = 32'd123456;
        @(posedge hwclk);
        #1 bus.start = 1'b0;
        lat = 0;
        while (!bus.digit_valid && lat < 200) begin
            @(posedge hwclk);
            #1 lat++;
        end
        check("rstmid_latency", lat, 37);
        @(posedge hwclk);
        @(posedge hwclk);
        #3 reset = 1'b1;
        #1;
        check("rstmid_valid", bus.digit_valid, 0);
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_last", bus.last, 0);
        check("rstmid_done", bus.done, 0);
        check("rstmid_popped", sb.size(), 4);
        sb.delete();
        @(posedge hwclk);
        #2 reset = 1'b0;
        @(posedge hwclk);
        #1;
        check("rstmid_no_done", done_cnt - d0, 0);
        run_one(32'd42, 41, 2, 1'b0, 1'b0, "after_rst");

        // start held high: back-to-back conversions with one IDLE cycle between
        d0 = done_cnt;
        push_expected(32'd58);
        push_expected(32'd58);
        @(posedge hwclk);
        #2 bus.start = 1'b1; bus.value = 32'd58;
        seen = 0;
        cyc = 0;
        while (seen < 2 && cyc < 400) begin
            @(posedge hwclk);
            #1 cyc++;
            if (bus.done) begin
                seen++;
                check("held_idle_at_done", bus.busy, 0);
                if (seen == 2) begin
                    bus.start = 1'b0;
                end else begin
                    @(posedge hwclk);
                    #1 cyc++;
                    check("held_restart", bus.busy, 1);
                end
            end
        end
        check("held_done_seen", seen, 2);
        @(posedge hwclk);
        #1;
        check("held_done_count", done_cnt - d0, 2);
        check("held_sb_empty", sb.size(), 0);
        check("held_stop", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
